// File: rtl/ex_stage_pkg.sv
// Shared opcodes, memory-op codes, divider state encoding and helpers for the execute stage.
package ex_stage_pkg;

  localparam int ALU_OP_W   = 5;
  localparam int DIV_CYCLES = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Five opcode bits: the full operation set needs more than sixteen codes.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_ADDU  = 5'd2,
    ALU_SUB   = 5'd3,
    ALU_SUBU  = 5'd4,
    ALU_AND   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_XOR   = 5'd7,
    ALU_NOR   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_SLL   = 5'd11,
    ALU_SRL   = 5'd12,
    ALU_SRA   = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MULT  = 5'd15,
    ALU_MULTU = 5'd16,
    ALU_MFHI  = 5'd17,
    ALU_MFLO  = 5'd18,
    ALU_MTHI  = 5'd19,
    ALU_MTLO  = 5'd20,
    ALU_DIV   = 5'd21,
    ALU_DIVU  = 5'd22
  } alu_op_e;

  typedef enum logic [2:0] {
    MEM_NOP_OP = 3'd0,
    LOAD_BYTE  = 3'd1,
    LOAD_HALF  = 3'd2,
    LOAD_WORD  = 3'd3,
    SAVE_BYTE  = 3'd4,
    SAVE_HALF  = 3'd5,
    SAVE_WORD  = 3'd6
  } mem_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_stage_divider.sv
// Radix-2 restoring divider (one quotient bit per cycle) with IDLE/RUN/DONE control.
module ex_divider
  import ex_stage_pkg::*;
#(
  parameter int CYCLES = DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  localparam int CW = $clog2(CYCLES + 1);

  div_state_e  state, state_nx;
  logic [CW-1:0] count;
  logic [31:0] q_r, r_r, d_r;
  logic        neg_q, neg_r;
  logic [32:0] shifted, diff;

  assign shifted = {r_r, q_r[31]};
  assign diff    = shifted - {1'b0, d_r};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DIV_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE: if (start && !abort) state_nx = (b == ZERO_WORD) ? DIV_DONE : DIV_RUN;
      DIV_RUN: begin
        if (abort)                             state_nx = DIV_IDLE;
        else if (count == CW'(CYCLES - 1))     state_nx = DIV_DONE;
      end
      DIV_DONE: state_nx = DIV_IDLE;
      default:  state_nx = DIV_IDLE;
    endcase
  end

  // A zero divisor skips the iterations and preloads the architectural result directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      q_r   <= ZERO_WORD;
      r_r   <= ZERO_WORD;
      d_r   <= ZERO_WORD;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == DIV_IDLE) begin
      if (start && !abort) begin
        count <= '0;
        if (b == ZERO_WORD) begin
          q_r   <= 32'hFFFF_FFFF;
          r_r   <= a;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else begin
          q_r   <= abs32(a, is_signed);
          r_r   <= ZERO_WORD;
          d_r   <= abs32(b, is_signed);
          neg_q <= is_signed && (a[31] ^ b[31]);
          neg_r <= is_signed && a[31];
        end
      end
    end else if (state == DIV_RUN) begin
      count <= count + 1'b1;
      q_r   <= {q_r[30:0], ~diff[32]};
      r_r   <= diff[32] ? shifted[31:0] : diff[31:0];
    end
  end

  assign busy = (state == DIV_RUN);
  assign done = (state == DIV_DONE);
  assign quot = neg_q ? (~q_r + 32'd1) : q_r;
  assign rem  = neg_r ? (~r_r + 32'd1) : r_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage with HI/LO and the EX/MEM pipeline register.
// Define EX_DIV_EN to build the iterative divider; otherwise DIV/DIVU become bubbles.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_OP_W-1:0] AluOp_i,
  input  logic [31:0]         SrcA_i,
  input  logic [31:0]         SrcB_i,
  input  logic [31:0]         MemData_i,
  input  logic                RegWrite_i,
  input  logic [4:0]          WriteRegDst_i,
  input  logic [2:0]          MemOp_i,
  input  logic                flush_i,
  output logic [31:0]         result_o,
  output logic [31:0]         MemData_o,
  output logic                RegWrite_o,
  output logic [4:0]          WriteRegDst_o,
  output logic [2:0]          MemOp_o,
  output logic                stall_o,
  output logic [31:0]         hi_o,
  output logic [31:0]         lo_o
);

  logic [31:0] hi, lo, hi_fwd, lo_fwd, alu_res, sra_res;
  logic [31:0] div_quot, div_rem;
  logic [63:0] mul_s, mul_u;
  logic        div_op, is_mult, bubble, div_wr;

  assign div_op  = (AluOp_i == ALU_DIV) || (AluOp_i == ALU_DIVU);
  assign is_mult = (AluOp_i == ALU_MULT) || (AluOp_i == ALU_MULTU);

`ifdef EX_DIV_EN
  logic div_busy, div_done, div_start;

  // The DIV itself stays in EX while the divider runs, so a new start is only taken from IDLE.
  assign div_start = div_op && !flush_i && !div_busy && !div_done;
  assign stall_o   = div_start || (div_busy && !flush_i);
  assign div_wr    = div_done && !flush_i;

  ex_divider #(.CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (AluOp_i == ALU_DIV),
    .a         (SrcA_i),
    .b         (SrcB_i),
    .abort     (flush_i),
    .busy      (div_busy),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );
`else
  assign stall_o  = 1'b0;
  assign div_wr   = 1'b0;
  assign div_quot = ZERO_WORD;
  assign div_rem  = ZERO_WORD;
`endif

  assign hi_fwd  = div_wr ? div_rem  : hi;
  assign lo_fwd  = div_wr ? div_quot : lo;
  assign mul_s   = {{32{SrcA_i[31]}}, SrcA_i} * {{32{SrcB_i[31]}}, SrcB_i};
  assign mul_u   = {32'h0, SrcA_i} * {32'h0, SrcB_i};
  assign sra_res = $signed(SrcB_i) >>> SrcA_i[4:0];
  assign bubble  = stall_o || flush_i || div_op;

  always_comb begin
    alu_res = ZERO_WORD;
    case (AluOp_i)
      ALU_ADD, ALU_ADDU: alu_res = SrcA_i + SrcB_i;
      ALU_SUB, ALU_SUBU: alu_res = SrcA_i - SrcB_i;
      ALU_AND:  alu_res = SrcA_i & SrcB_i;
      ALU_OR:   alu_res = SrcA_i | SrcB_i;
      ALU_XOR:  alu_res = SrcA_i ^ SrcB_i;
      ALU_NOR:  alu_res = ~(SrcA_i | SrcB_i);
      ALU_SLT:  alu_res = {31'h0, $signed(SrcA_i) < $signed(SrcB_i)};
      ALU_SLTU: alu_res = {31'h0, SrcA_i < SrcB_i};
      ALU_SLL:  alu_res = SrcB_i << SrcA_i[4:0];
      ALU_SRL:  alu_res = SrcB_i >> SrcA_i[4:0];
      ALU_SRA:  alu_res = sra_res;
      ALU_LUI:  alu_res = {SrcB_i[15:0], 16'h0};
      ALU_MFHI: alu_res = hi_fwd;
      ALU_MFLO: alu_res = lo_fwd;
      default:  alu_res = ZERO_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o      <= ZERO_WORD;
      MemData_o     <= ZERO_WORD;
      RegWrite_o    <= 1'b0;
      WriteRegDst_o <= 5'd0;
      MemOp_o       <= MEM_NOP_OP;
    end else if (bubble) begin
      result_o      <= ZERO_WORD;
      MemData_o     <= ZERO_WORD;
      RegWrite_o    <= 1'b0;
      WriteRegDst_o <= 5'd0;
      MemOp_o       <= MEM_NOP_OP;
    end else begin
      result_o      <= alu_res;
      MemData_o     <= MemData_i;
      RegWrite_o    <= RegWrite_i && !is_mult;
      WriteRegDst_o <= WriteRegDst_i;
      MemOp_o       <= MemOp_i;
    end
  end

  // A finishing divide owns HI/LO on its edge; the instruction in EX then is the DIV itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else if (div_wr) begin
      hi <= div_rem;
      lo <= div_quot;
    end else if (!stall_o && !flush_i) begin
      case (AluOp_i)
        ALU_MULT:  {hi, lo} <= mul_s;
        ALU_MULTU: {hi, lo} <= mul_u;
        ALU_MTHI:  hi <= SrcA_i;
        ALU_MTLO:  lo <= SrcA_i;
        default: ;
      endcase
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage; divider expectations follow EX_DIV_EN.
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef EX_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_op;
  logic [31:0] src_a, src_b, mem_data;
  logic        reg_write, flush;
  logic [4:0]  write_reg_dst;
  logic [2:0]  mem_op;
  logic [31:0] res_out, md_out, hi, lo;
  logic        rw_out, stall;
  logic [4:0]  dst_out;
  logic [2:0]  mop_out;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] md;
    logic        rw;
    logic [4:0]  dst;
    logic [2:0]  mop;
    logic        fl;
    logic [31:0] e_res;
  } vec_t;

  vec_t vecs[20];

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .AluOp_i       (alu_op),
    .SrcA_i        (src_a),
    .SrcB_i        (src_b),
    .MemData_i     (mem_data),
    .RegWrite_i    (reg_write),
    .WriteRegDst_i (write_reg_dst),
    .MemOp_i       (mem_op),
    .flush_i       (flush),
    .result_o      (res_out),
    .MemData_o     (md_out),
    .RegWrite_o    (rw_out),
    .WriteRegDst_o (dst_out),
    .MemOp_o       (mop_out),
    .stall_o       (stall),
    .hi_o          (hi),
    .lo_o          (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] md, input logic rw, input logic [4:0] dst,
                                input logic [2:0] mop, input logic fl);
    alu_op        = op;
    src_a         = a;
    src_b         = b;
    mem_data      = md;
    reg_write     = rw;
    write_reg_dst = dst;
    mem_op        = mop;
    flush         = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_nop();
    apply_stimulus(ALU_NOP, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b0);
  endtask

  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string tag);
    int n;
    apply_stimulus(op, a, b, 32'd0, 1'b1, 5'd7, MEM_NOP_OP, 1'b0);
    #1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_output({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
    step();
    apply_nop();
    check_output({tag, "_hi"}, hi, exp_hi);
    check_output({tag, "_lo"}, lo, exp_lo);
    check_output({tag, "_regwrite"}, 32'(rw_out), 32'd0);
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  initial begin
    vecs[0]  = '{ALU_ADD,  32'd5,        32'd7,        32'd0,        1'b1, 5'd3,  MEM_NOP_OP, 1'b0, 32'd12};
    vecs[1]  = '{ALU_ADD,  32'h100,      32'd4,        32'hDEADBEEF, 1'b0, 5'd0,  SAVE_WORD,  1'b0, 32'h104};
    vecs[2]  = '{ALU_ADDU, 32'hFFFFFFFF, 32'd2,        32'd0,        1'b1, 5'd4,  MEM_NOP_OP, 1'b0, 32'd1};
    vecs[3]  = '{ALU_SUB,  32'd3,        32'd5,        32'd0,        1'b1, 5'd5,  MEM_NOP_OP, 1'b0, 32'hFFFFFFFE};
    vecs[4]  = '{ALU_SUBU, 32'd0,        32'd1,        32'd0,        1'b1, 5'd6,  MEM_NOP_OP, 1'b0, 32'hFFFFFFFF};
    vecs[5]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b1, 5'd7,  MEM_NOP_OP, 1'b0, 32'hF000F000};
    vecs[6]  = '{ALU_OR,   32'h000000F0, 32'h00000F00, 32'd0,        1'b1, 5'd8,  MEM_NOP_OP, 1'b0, 32'h00000FF0};
    vecs[7]  = '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFF0000, 32'd0,        1'b1, 5'd9,  MEM_NOP_OP, 1'b0, 32'h5555AAAA};
    vecs[8]  = '{ALU_NOR,  32'd0,        32'h0000FFFF, 32'd0,        1'b1, 5'd10, MEM_NOP_OP, 1'b0, 32'hFFFF0000};
    vecs[9]  = '{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 5'd11, MEM_NOP_OP, 1'b0, 32'd1};
    vecs[10] = '{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 5'd12, MEM_NOP_OP, 1'b0, 32'd0};
    vecs[11] = '{ALU_SLT,  32'd1,        32'h80000000, 32'd0,        1'b1, 5'd13, MEM_NOP_OP, 1'b0, 32'd0};
    vecs[12] = '{ALU_SLL,  32'd4,        32'h0000000F, 32'd0,        1'b1, 5'd14, MEM_NOP_OP, 1'b0, 32'h000000F0};
    vecs[13] = '{ALU_SRL,  32'd4,        32'h80000000, 32'd0,        1'b1, 5'd15, MEM_NOP_OP, 1'b0, 32'h08000000};
    vecs[14] = '{ALU_SRA,  32'd4,        32'h80000000, 32'd0,        1'b1, 5'd16, MEM_NOP_OP, 1'b0, 32'hF8000000};
    vecs[15] = '{ALU_SRA,  32'h3F,       32'h7FFFFFFF, 32'd0,        1'b1, 5'd17, MEM_NOP_OP, 1'b0, 32'd0};
    vecs[16] = '{ALU_LUI,  32'd0,        32'h1234ABCD, 32'd0,        1'b1, 5'd18, MEM_NOP_OP, 1'b0, 32'hABCD0000};
    vecs[17] = '{ALU_ADD,  32'h200,      32'hFFFFFFFC, 32'd0,        1'b1, 5'd8,  LOAD_WORD,  1'b0, 32'h1FC};
    vecs[18] = '{ALU_ADD,  32'd1,        32'd1,        32'h55,       1'b1, 5'd31, SAVE_BYTE,  1'b1, 32'd0};
    vecs[19] = '{ALU_SLL,  32'h20,       32'h12345678, 32'd0,        1'b1, 5'd1,  MEM_NOP_OP, 1'b0, 32'h12345678};

    rst = 1'b0;
    apply_stimulus(ALU_ADD, 32'd9, 32'd9, 32'h77, 1'b1, 5'd2, LOAD_WORD, 1'b0);
    #2;
    check_output("reset_result", res_out, 32'd0);
    check_output("reset_regwrite", 32'(rw_out), 32'd0);
    check_output("reset_memop", 32'(mop_out), 32'(MEM_NOP_OP));
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    check_output("reset_stall", 32'(stall), 32'd0);
    apply_nop();
    #10;
    rst = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].md, vecs[i].rw,
                     vecs[i].dst, vecs[i].mop, vecs[i].fl);
      step();
      check_output($sformatf("v%0d_result", i), res_out, vecs[i].e_res);
      check_output($sformatf("v%0d_memdata", i), md_out, vecs[i].fl ? 32'd0 : vecs[i].md);
      check_output($sformatf("v%0d_regwrite", i), 32'(rw_out), vecs[i].fl ? 32'd0 : 32'(vecs[i].rw));
      check_output($sformatf("v%0d_dst", i), 32'(dst_out), vecs[i].fl ? 32'd0 : 32'(vecs[i].dst));
      check_output($sformatf("v%0d_memop", i), 32'(mop_out), vecs[i].fl ? 32'(MEM_NOP_OP) : 32'(vecs[i].mop));
    end

    apply_stimulus(ALU_MULT, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 5'd4, MEM_NOP_OP, 1'b0);
    step();
    check_output("mult_hi", hi, 32'hFFFFFFFF);
    check_output("mult_lo", lo, 32'hFFFFFFFE);
    check_output("mult_regwrite", 32'(rw_out), 32'd0);
    apply_stimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b1, 5'd5, MEM_NOP_OP, 1'b0);
    step();
    check_output("mflo_result", res_out, 32'hFFFFFFFE);
    check_output("mflo_regwrite", 32'(rw_out), 32'd1);
    apply_stimulus(ALU_MFHI, 32'd0, 32'd0, 32'd0, 1'b1, 5'd5, MEM_NOP_OP, 1'b0);
    step();
    check_output("mfhi_result", res_out, 32'hFFFFFFFF);
    apply_stimulus(ALU_MULTU, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b0);
    step();
    check_output("multu_hi", hi, 32'd1);
    check_output("multu_lo", lo, 32'hFFFFFFFE);
    apply_stimulus(ALU_MTHI, 32'h11111111, 32'd0, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b0);
    step();
    check_output("mthi_hi", hi, 32'h11111111);
    check_output("mthi_lo", lo, 32'hFFFFFFFE);
    apply_stimulus(ALU_MTLO, 32'h22222222, 32'd0, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b0);
    step();
    check_output("mtlo_lo", lo, 32'h22222222);
    apply_stimulus(ALU_MULT, 32'd3, 32'd3, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b1);
    step();
    check_output("flushed_mult_hi", hi, 32'h11111111);
    check_output("flushed_mult_lo", lo, 32'h22222222);
    m_hi = 32'h11111111;
    m_lo = 32'h22222222;

    run_div(ALU_DIVU, 32'd100, 32'd7, DIV_EN ? 33 : 0,
            DIV_EN ? 32'd2 : m_hi, DIV_EN ? 32'd14 : m_lo, "divu_100_7");
    apply_stimulus(ALU_MFLO, 32'd0, 32'd0, 32'd0, 1'b1, 5'd2, MEM_NOP_OP, 1'b0);
    step();
    check_output("mflo_after_div", res_out, m_lo);
    run_div(ALU_DIV, 32'hFFFFFFF9, 32'd2, DIV_EN ? 33 : 0,
            DIV_EN ? 32'hFFFFFFFF : m_hi, DIV_EN ? 32'hFFFFFFFD : m_lo, "div_m7_2");
    run_div(ALU_DIV, 32'h12345678, 32'd0, DIV_EN ? 1 : 0,
            DIV_EN ? 32'h12345678 : m_hi, DIV_EN ? 32'hFFFFFFFF : m_lo, "div_by_zero");
    run_div(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_EN ? 33 : 0,
            DIV_EN ? 32'd0 : m_hi, DIV_EN ? 32'h80000000 : m_lo, "div_min_m1");
    run_div(ALU_DIVU, 32'hFFFFFFFF, 32'h10, DIV_EN ? 33 : 0,
            DIV_EN ? 32'hF : m_hi, DIV_EN ? 32'h0FFFFFFF : m_lo, "divu_max_16");

`ifdef EX_DIV_EN
    apply_stimulus(ALU_DIVU, 32'd1000, 32'd3, 32'd0, 1'b1, 5'd7, MEM_NOP_OP, 1'b0);
    #1;
    check_output("flush_start_stall", 32'(stall), 32'd1);
    repeat (11) @(posedge clk);
    #1;
    check_output("flush_run10_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    #1;
    check_output("flush_stall_drop", 32'(stall), 32'd0);
    step();
    check_output("flush_bubble_regwrite", 32'(rw_out), 32'd0);
    check_output("flush_bubble_result", res_out, 32'd0);
    apply_nop();
    #1;
    check_output("flush_after_stall", 32'(stall), 32'd0);
    repeat (3) step();
    check_output("flush_idle_stall", 32'(stall), 32'd0);
    check_output("flush_hi_kept", hi, m_hi);
    check_output("flush_lo_kept", lo, m_lo);
`endif

    apply_stimulus(ALU_ADD, 32'h10, 32'h20, 32'hCAFE, 1'b1, 5'd9, LOAD_WORD, 1'b0);
    step();
    check_output("pre_reset_result", res_out, 32'h30);
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset_result", res_out, 32'd0);
    check_output("async_reset_memdata", md_out, 32'd0);
    check_output("async_reset_dst", 32'(dst_out), 32'd0);
    check_output("async_reset_memop", 32'(mop_out), 32'(MEM_NOP_OP));
    #4;
    rst = 1'b1;

    apply_stimulus(ALU_MTHI, 32'h0BADF00D, 32'd0, 32'd0, 1'b0, 5'd0, MEM_NOP_OP, 1'b0);
    step();
    apply_stimulus(ALU_DIVU, 32'd50, 32'd5, 32'd0, 1'b1, 5'd7, MEM_NOP_OP, 1'b0);
    repeat (5) step();
    check_output("middiv_pre_hi", hi, 32'h0BADF00D);
    #2;
    rst = 1'b0;
    #1;
    check_output("middiv_reset_hi", hi, 32'd0);
    check_output("middiv_reset_lo", lo, 32'd0);
    check_output("middiv_reset_regwrite", 32'(rw_out), 32'd0);
    apply_nop();
    #1;
    check_output("middiv_reset_stall", 32'(stall), 32'd0);
    #2;
    rst = 1'b1;
    apply_stimulus(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b1, 5'd2, MEM_NOP_OP, 1'b0);
    step();
    check_output("post_reset_add", res_out, 32'd2);
    check_output("post_reset_stall", 32'(stall), 32'd0);
    check_output("post_reset_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
